// File: rtl/mem_responder_pkg.sv
// Shared constants, state encoding and byte-merge helper for the memory responder.
package mem_pkg;

    localparam int unsigned CPU_ADDR_BITS = 32;
    localparam int unsigned CPU_INST_BITS = 32;
    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned MEM_MASK_BITS = MEM_DATA_BITS / 8;
    localparam int unsigned MEM_ADDR_BITS =
        CPU_ADDR_BITS - 2 - $clog2(MEM_DATA_BITS / CPU_INST_BITS);

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RWAIT = 2'd1;
    localparam state_t RESP  = 2'd2;
    localparam state_t WDATA = 2'd3;

    // Replace each byte of old_word whose mask bit is set with the same byte of new_word.
    function automatic logic [MEM_DATA_BITS-1:0] mask_merge(
        input logic [MEM_DATA_BITS-1:0] old_word,
        input logic [MEM_DATA_BITS-1:0] new_word,
        input logic [MEM_MASK_BITS-1:0] mask
    );
        logic [MEM_DATA_BITS-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MEM_MASK_BITS; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle.
interface mem_responder_if #(
    parameter int unsigned MEM_ADDR_BITS = mem_pkg::MEM_ADDR_BITS,
    parameter int unsigned MEM_DATA_BITS = mem_pkg::MEM_DATA_BITS
);

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
    logic                       mem_req_rw;
    logic                       mem_req_data_valid;
    logic                       mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
    logic                       mem_resp_valid;
    logic [MEM_DATA_BITS-1:0]   mem_resp_data;

    // Cache side
    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    // Memory side
    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_responder_byte_array.sv
// Single-port backing store: byte-masked synchronous write, combinational read.
module mem_byte_array import mem_pkg::*; #(
    parameter int unsigned DEPTH_BITS = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DEPTH_BITS-1:0]    idx,
    input  logic [MEM_DATA_BITS-1:0] wdata,
    input  logic [MEM_MASK_BITS-1:0] wmask,
    output logic [MEM_DATA_BITS-1:0] rdata
);

    logic [MEM_DATA_BITS-1:0] mem_q [2**DEPTH_BITS];

    // Contents are deliberately not reset; only masked bytes change on a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= mask_merge(mem_q[idx], wdata, wmask);
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory endpoint: accepts one command at a time, services writes into the
// byte array and returns read data after a fixed latency.
module mem_responder import mem_pkg::*; #(
    parameter int unsigned DEPTH_BITS    = 12,
    parameter int unsigned LATENCY       = 4,
    parameter int unsigned MEM_ADDR_BITS = mem_pkg::MEM_ADDR_BITS
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0]    idx_q, idx_d;
    logic [MEM_DATA_BITS-1:0] hold_q, hold_d;

    logic                     wr_en;
    logic [DEPTH_BITS-1:0]    req_idx;
    logic [DEPTH_BITS-1:0]    arr_idx;
    logic [MEM_DATA_BITS-1:0] arr_rd;
    logic                     resp_valid;
    logic                     unused_addr_hi;

    // Upper beat-address bits alias onto the array and are intentionally dropped.
    assign req_idx        = bus.mem_req_addr[DEPTH_BITS-1:0];
    assign unused_addr_hi = ^bus.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

    // Next-state, counter, address latch and array write/port-select logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        arr_idx = idx_q;
        case (state_q)
            IDLE: begin
                // Same-cycle writes use the incoming address on the single port.
                arr_idx = req_idx;
                if (bus.mem_req_valid) begin
                    if (bus.mem_req_rw) begin
                        if (bus.mem_req_data_valid) begin
                            wr_en = 1'b1;
                        end else begin
                            idx_d   = req_idx;
                            state_d = WDATA;
                        end
                    end else begin
                        idx_d   = req_idx;
                        cnt_d   = LAT_M1;
                        state_d = (LATENCY == 1) ? RESP : RWAIT;
                    end
                end
            end
            RWAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            WDATA: begin
                if (bus.mem_req_data_valid) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset overrides any handshake in the same cycle.
        if (reset) begin
            wr_en = 1'b0;
        end
    end

    // Response data is held between pulses so the output is stable when not valid.
    always_comb begin
        hold_d = resp_valid ? arr_rd : hold_q;
    end

    // State, counter, latched index and held response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign resp_valid             = !reset && (state_q == RESP);
    assign bus.mem_req_ready      = !reset && (state_q == IDLE);
    assign bus.mem_req_data_ready = !reset && ((state_q == WDATA) ||
                                    ((state_q == IDLE) && bus.mem_req_valid && bus.mem_req_rw));
    assign bus.mem_resp_valid     = resp_valid;
    assign bus.mem_resp_data      = resp_valid ? arr_rd : hold_q;

    mem_byte_array #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .idx   (arr_idx),
        .wdata (bus.mem_req_data_bits),
        .wmask (bus.mem_req_data_mask),
        .rdata (arr_rd)
    );

endmodule
